// File: rtl/primogen_arbiter.sv
// primogen_arbiter: round-robin sharing of one primogen between N requesters.
// Each grant delivers the current primogen result, then pulses go to advance
// the sequence. A one-cycle GAP lets primogen drop ready before the next look.
// Overflow from primogen parks the block in an absorbing FAULT state.
module primogen_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     ack_o,
    output logic [WIDTH-1:0] prime_o,
    output logic             pg_go_o,
    input  logic             pg_ready_i,
    input  logic             pg_error_i,
    input  logic [WIDTH-1:0] pg_res_i,
    output logic             busy_o,
    output logic             fault_o,
    output logic [CW-1:0]    served_o
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_FAULT} state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    last_q, last_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [WIDTH-1:0] prime_q, prime_d;
    logic             go_q, go_d;
    logic             busy_q, fault_q;
    logic [CW-1:0]    served_q, served_d;
    logic [LW-1:0]    gnt;
    logic             gnt_vld;

    // Round-robin pick: first set request scanning last+1, last+2, ... mod N
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!gnt_vld && req_i[LW'((int'(last_q) + k) % N)]) begin
                gnt_vld = 1'b1;
                gnt     = LW'((int'(last_q) + k) % N);
            end
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        ack_d    = '0;
        go_d     = 1'b0;
        prime_d  = prime_q;
        served_d = served_q;
        case (state_q)
            S_IDLE: begin
                if (pg_ready_i) begin
                    if (pg_error_i) begin
                        state_d = S_FAULT;
                    end else if (gnt_vld) begin
                        ack_d[gnt] = 1'b1;
                        prime_d    = pg_res_i;
                        go_d       = 1'b1;
                        last_d     = gnt;
                        if (served_q != '1) served_d = served_q + 1'b1;
                        state_d    = S_GAP;
                    end
                end
            end
            // ack/go are visible here; primogen sees go and drops ready
            S_GAP:   state_d = S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; rst overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_q   <= LW'(N - 1);
            ack_q    <= '0;
            prime_q  <= '0;
            go_q     <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
            prime_q  <= prime_d;
            go_q     <= go_d;
            busy_q   <= (state_d == S_GAP);
            fault_q  <= (state_d == S_FAULT);
            served_q <= served_d;
        end
    end

    assign ack_o    = ack_q;
    assign prime_o  = prime_q;
    assign pg_go_o  = go_q;
    assign busy_o   = busy_q;
    assign fault_o  = fault_q;
    assign served_o = served_q;

endmodule
